// File: rtl/t_switch_pipe_if.sv
// Port bundle for the buffered BFT T-switch: the three packet inputs with
// their ready outputs, and the three packet outputs with their ready inputs.
// The switch uses the slave modport; the neighbouring logic uses master.
interface t_switch_pipe_if #(
  parameter int p_sz = 52
);
  logic [p_sz-1:0] l_bus_i, r_bus_i, u_bus_i;
  logic            l_rdy_o, r_rdy_o, u_rdy_o;
  logic [p_sz-1:0] l_bus_o, r_bus_o, u_bus_o;
  logic            l_rdy_i, r_rdy_i, u_rdy_i;

  modport slave (
    input  l_bus_i, r_bus_i, u_bus_i, l_rdy_i, r_rdy_i, u_rdy_i,
    output l_rdy_o, r_rdy_o, u_rdy_o, l_bus_o, r_bus_o, u_bus_o
  );

  modport master (
    output l_bus_i, r_bus_i, u_bus_i, l_rdy_i, r_rdy_i, u_rdy_i,
    input  l_rdy_o, r_rdy_o, u_rdy_o, l_bus_o, r_bus_o, u_bus_o
  );
endinterface

// File: rtl/t_switch_pipe.sv
// Buffered, back-pressured BFT T-switch (left child, right child, parent).
// Each input has a small FIFO; each output has a register fed by a two-way
// round-robin arbiter over the FIFO heads routed to it. Misrouted heads are
// popped and discarded. Index convention throughout: 0 = l, 1 = r, 2 = u.
// Optional build macro T_SWITCH_PERF_EN adds saturating forward/drop counters.
module t_switch_pipe #(
  parameter int num_leaves = 256,
  parameter int payload_sz = 43,
  parameter int p_sz       = 52,
  parameter int addr       = 0,
  parameter int level      = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  t_switch_pipe_if.slave sw
`ifdef T_SWITCH_PERF_EN
  ,
  output logic [31:0]    fwd_cnt_l,
  output logic [31:0]    fwd_cnt_r,
  output logic [31:0]    fwd_cnt_u,
  output logic [15:0]    drop_cnt
`endif
);

  localparam int addr_sz = $clog2(num_leaves);
  localparam int ptr_sz  = $clog2(FIFO_DEPTH);
  localparam int cnt_sz  = ptr_sz + 1;

  if (p_sz != 1 + addr_sz + payload_sz) begin : g_bad_p_sz
    $error("t_switch_pipe: p_sz must equal 1 + addr_sz + payload_sz");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("t_switch_pipe: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef logic [p_sz-1:0] pkt_t;

  pkt_t              in_bus   [3];
  pkt_t              head     [3];
  pkt_t              out_reg  [3];
  pkt_t              out_next [3];
  pkt_t              mem      [3][FIFO_DEPTH];
  logic [ptr_sz-1:0] rd_ptr   [3];
  logic [ptr_sz-1:0] wr_ptr   [3];
  logic [cnt_sz-1:0] count    [3];
  logic [1:0]        route    [3];
  logic [2:0]        head_vld, in_rdy, out_rdy, push, pop, drop;
  logic [2:0]        ld_en, gnt, sel_b, arb_ptr;

  // Destination output for a packet address: 0 = l, 1 = r, 2 = u.
  function automatic logic [1:0] route_of(input logic [addr_sz-1:0] dest);
    if ((dest >> (level + 1)) != addr_sz'(addr)) return 2'd2;
    return dest[level] ? 2'd1 : 2'd0;
  endfunction

  assign in_bus[0]  = sw.l_bus_i;
  assign in_bus[1]  = sw.r_bus_i;
  assign in_bus[2]  = sw.u_bus_i;
  assign out_rdy    = {sw.u_rdy_i, sw.r_rdy_i, sw.l_rdy_i};
  assign sw.l_rdy_o = in_rdy[0];
  assign sw.r_rdy_o = in_rdy[1];
  assign sw.u_rdy_o = in_rdy[2];
  assign sw.l_bus_o = out_reg[0];
  assign sw.r_bus_o = out_reg[1];
  assign sw.u_bus_o = out_reg[2];

  // FIFO heads, their routes, misroute detection and input-side acceptance.
  always_comb begin
    head     = '{default: '0};
    route    = '{default: '0};
    head_vld = '0;
    drop     = '0;
    in_rdy   = '0;
    push     = '0;
    for (int i = 0; i < 3; i++) begin
      head[i]     = mem[i][rd_ptr[i]];
      head_vld[i] = (count[i] != '0);
      route[i]    = route_of(head[i][p_sz-2 -: addr_sz]);
      drop[i]     = head_vld[i] && (route[i] == 2'(i));
      in_rdy[i]   = !reset && (count[i] != cnt_sz'(FIFO_DEPTH));
      push[i]     = in_bus[i][p_sz-1] && in_rdy[i];
    end
  end

  // Per-output round-robin between its two possible sources; pops the winner.
  always_comb begin
    logic [1:0] ra;
    logic [1:0] rb;
    logic       want_a;
    logic       want_b;
    ra       = '0;
    rb       = '0;
    want_a   = 1'b0;
    want_b   = 1'b0;
    pop      = drop;
    ld_en    = '0;
    sel_b    = '0;
    gnt      = '0;
    out_next = '{default: '0};
    for (int o = 0; o < 3; o++) begin
      // Source a is the reset-preferred one: l for outputs r and u, r for output l.
      ra        = (o == 0) ? 2'd1 : 2'd0;
      rb        = (o == 2) ? 2'd1 : 2'd2;
      want_a    = head_vld[ra] && (route[ra] == 2'(o));
      want_b    = head_vld[rb] && (route[rb] == 2'(o));
      ld_en[o]  = !out_reg[o][p_sz-1] || out_rdy[o];
      sel_b[o]  = want_b && (!want_a || arb_ptr[o]);
      gnt[o]    = ld_en[o] && (want_a || want_b);
      if (gnt[o]) begin
        if (sel_b[o]) begin
          out_next[o] = head[rb];
          pop[rb]     = 1'b1;
        end else begin
          out_next[o] = head[ra];
          pop[ra]     = 1'b1;
        end
      end
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + ptr_sz'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + ptr_sz'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + cnt_sz'(1);
        else if (!push[i] && pop[i]) count[i] <= count[i] - cnt_sz'(1);
      end
    end
  end

  // FIFO storage; stale entries are harmless because count gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_bus[i];
    end
  end

  // Output registers reload when empty or drained; pointer flips after a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg <= '{default: '0};
      arb_ptr <= '0;
    end else begin
      for (int o = 0; o < 3; o++) begin
        if (ld_en[o]) out_reg[o] <= out_next[o];
        if (gnt[o])   arb_ptr[o] <= !sel_b[o];
      end
    end
  end

`ifdef T_SWITCH_PERF_EN
  logic [1:0]  drop_n;
  logic [16:0] drop_sum;

  assign drop_n   = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
  assign drop_sum = {1'b0, drop_cnt} + 17'(drop_n);

  // Saturating delivery and drop counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt_l <= '0;
      fwd_cnt_r <= '0;
      fwd_cnt_u <= '0;
      drop_cnt  <= '0;
    end else begin
      if (out_reg[0][p_sz-1] && out_rdy[0] && fwd_cnt_l != '1) fwd_cnt_l <= fwd_cnt_l + 32'd1;
      if (out_reg[1][p_sz-1] && out_rdy[1] && fwd_cnt_r != '1) fwd_cnt_r <= fwd_cnt_r + 32'd1;
      if (out_reg[2][p_sz-1] && out_rdy[2] && fwd_cnt_u != '1) fwd_cnt_u <= fwd_cnt_u + 32'd1;
      drop_cnt <= drop_sum[16] ? '1 : drop_sum[15:0];
    end
  end
`endif

endmodule
